// File: rtl/cpu_pkg.sv
// Shared CPU control-path widths, reset/vector defaults and flag bit positions.
package cpu_pkg;
  localparam int FLAG_W = 5;
  localparam int STEP_W = 4;
  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] RESET_PC_DEF   = 16'h0000;
  localparam logic [WORD_W-1:0] IRQ_VECTOR_DEF = 16'h0004;

  // Bit positions inside the flags register
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;
  localparam int FLAG_H = 4;

  // Microcode strobes sampled at each edge
  typedef struct packed {
    logic counter_rst;
    logic pcw;
    logic pc_write_from_d;
    logic d_to_instr;
    logic w_flags;
    logic enable_interrupts;
  } strobe_t;
endpackage

// File: rtl/next_pc_sel.sv
// PC priority mux: interrupt vector > load from data bus > increment > hold.
// strobe_pc is the value without interrupt entry; it doubles as the saved return address.
module next_pc_sel
  import cpu_pkg::*;
(
  input  logic [WORD_W-1:0] pc,
  input  logic [WORD_W-1:0] data_in,
  input  logic [WORD_W-1:0] irq_vector,
  input  logic              pcw,
  input  logic              pc_write_from_d,
  input  logic              irq_entry,
  output logic [WORD_W-1:0] strobe_pc,
  output logic [WORD_W-1:0] next_pc
);
  // Strobe-driven PC, then interrupt override on top
  always_comb begin
    strobe_pc = pc;
    if (pc_write_from_d) strobe_pc = data_in;
    else if (pcw)        strobe_pc = pc + 16'd1;
    next_pc = irq_entry ? irq_vector : strobe_pc;
  end
endmodule

// File: rtl/control_sequencer.sv
// Sequential front end of the control path: step counter, IR, PC, flags,
// interrupt enable/pending state and interrupt entry at instruction boundaries.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [WORD_W-1:0] IRQ_VECTOR = IRQ_VECTOR_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Stall,
  input  logic [WORD_W-1:0] DataIn,
  input  logic [FLAG_W-1:0] ALUFlags,
  input  logic              Irq,
  input  logic              CounterRST,
  input  logic              PCW,
  input  logic              PCWriteFromD,
  input  logic              DToInstr,
  input  logic              wFlags,
  input  logic              enableInterrupts,
  output logic [STEP_W-1:0] Counter,
  output logic [WORD_W-1:0] Instr,
  output logic [FLAG_W-1:0] Flags,
  output logic [WORD_W-1:0] PC,
  output logic [WORD_W-1:0] SavedPC,
  output logic              IntEnable,
  output logic              IrqAck,
  output logic              StepOverflow
);
  strobe_t           stb;
  logic              irq_pending;
  logic              entry;
  logic [WORD_W-1:0] strobe_pc;
  logic [WORD_W-1:0] next_pc;

  assign stb = '{counter_rst: CounterRST, pcw: PCW, pc_write_from_d: PCWriteFromD,
                 d_to_instr: DToInstr, w_flags: wFlags, enable_interrupts: enableInterrupts};

  // Entry only at an instruction boundary, using pre-edge enable/pending state
  assign entry = stb.counter_rst & IntEnable & irq_pending & ~Stall;

  next_pc_sel u_next_pc (
    .pc              (PC),
    .data_in         (DataIn),
    .irq_vector      (IRQ_VECTOR),
    .pcw             (stb.pcw),
    .pc_write_from_d (stb.pc_write_from_d),
    .irq_entry       (entry),
    .strobe_pc       (strobe_pc),
    .next_pc         (next_pc)
  );

  // Pending latch keeps sampling Irq during stalls; entry consumes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     irq_pending <= 1'b0;
    else if (entry) irq_pending <= 1'b0;
    else if (Irq)   irq_pending <= 1'b1;
  end

  // Architectural state, frozen while Stall is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Counter      <= '0;
      Instr        <= '0;
      Flags        <= '0;
      PC           <= RESET_PC;
      SavedPC      <= '0;
      IntEnable    <= 1'b0;
      IrqAck       <= 1'b0;
      StepOverflow <= 1'b0;
    end else if (Stall) begin
      IrqAck <= 1'b0;
    end else begin
      IrqAck <= entry;
      PC     <= next_pc;
      if (stb.counter_rst) Counter <= '0;
      else                 Counter <= Counter + 4'd1;
      if (!stb.counter_rst && Counter == 4'hF) StepOverflow <= 1'b1;
      if (stb.d_to_instr) Instr <= DataIn;
      if (stb.w_flags)    Flags <= ALUFlags;
      if (entry) begin
        SavedPC   <= strobe_pc;
        IntEnable <= 1'b0;
      end else if (stb.enable_interrupts) begin
        IntEnable <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_control_sequencer.sv
// Directed tests for control_sequencer: reset, fetch, branch/wrap, stall, interrupt, overflow.
module tb_control_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        Stall;
  logic [15:0] DataIn;
  logic [4:0]  ALUFlags;
  logic        Irq;
  logic        CounterRST, PCW, PCWriteFromD, DToInstr, wFlags, enableInterrupts;
  logic [3:0]  Counter;
  logic [15:0] Instr;
  logic [4:0]  Flags;
  logic [15:0] PC;
  logic [15:0] SavedPC;
  logic        IntEnable, IrqAck, StepOverflow;

  int tests = 0;
  int fails = 0;

  control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .Stall(Stall), .DataIn(DataIn), .ALUFlags(ALUFlags),
    .Irq(Irq), .CounterRST(CounterRST), .PCW(PCW), .PCWriteFromD(PCWriteFromD),
    .DToInstr(DToInstr), .wFlags(wFlags), .enableInterrupts(enableInterrupts),
    .Counter(Counter), .Instr(Instr), .Flags(Flags), .PC(PC), .SavedPC(SavedPC),
    .IntEnable(IntEnable), .IrqAck(IrqAck), .StepOverflow(StepOverflow)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Stall = 0; Irq = 0; CounterRST = 0; PCW = 0; PCWriteFromD = 0;
    DToInstr = 0; wFlags = 0; enableInterrupts = 0;
  endtask

  task automatic test_reset();
    idle(); DataIn = 16'hABCD; ALUFlags = 5'h1F;
    rst_n = 0;
    #12;
    tests++; if (Counter !== 4'h0 || PC !== 16'h0000 || Instr !== 16'h0000) begin
      fails++; $display("FAIL reset_init: Counter=%h PC=%h Instr=%h want 0/0000/0000", Counter, PC, Instr); end
    tests++; if (Flags !== 5'h0 || SavedPC !== 16'h0 || IntEnable !== 0 || IrqAck !== 0 || StepOverflow !== 0) begin
      fails++; $display("FAIL reset_misc: Flags=%h SavedPC=%h IE=%b Ack=%b Ovf=%b want zeros", Flags, SavedPC, IntEnable, IrqAck, StepOverflow); end
    @(negedge clk); rst_n = 1;
    // run mid-instruction with state changes, then abort asynchronously
    PCW = 1; DToInstr = 1; wFlags = 1; enableInterrupts = 1;
    cyc(); cyc();
    tests++; if (Counter !== 4'h2 || PC !== 16'h0002 || Flags !== 5'h1F || IntEnable !== 1) begin
      fails++; $display("FAIL reset_precount: Counter=%h PC=%h Flags=%h IE=%b want 2/0002/1f/1", Counter, PC, Flags, IntEnable); end
    #2; rst_n = 0; #1;
    tests++; if (Counter !== 4'h0 || PC !== 16'h0000 || Instr !== 16'h0 || Flags !== 5'h0 || IntEnable !== 0) begin
      fails++; $display("FAIL reset_async: Counter=%h PC=%h Instr=%h Flags=%h IE=%b want all zero", Counter, PC, Instr, Flags, IntEnable); end
    idle();
    @(negedge clk); rst_n = 1;
    #1;
    tests++; if (Counter !== 4'h0 || PC !== 16'h0000) begin
      fails++; $display("FAIL reset_release: Counter=%h PC=%h want 0/0000", Counter, PC); end
  endtask

  task automatic test_fetch();
    idle();
    cyc();                                  // step 0 -> 1
    DataIn = 16'h1234; DToInstr = 1; PCW = 1;
    cyc();                                  // step 1 -> 2
    tests++; if (Instr !== 16'h1234 || PC !== 16'h0001 || Counter !== 4'h2) begin
      fails++; $display("FAIL fetch: Instr=%h PC=%h Counter=%h want 1234/0001/2", Instr, PC, Counter); end
    idle(); ALUFlags = 5'h15; wFlags = 1;
    cyc();                                  // step 2 -> 3
    tests++; if (Flags !== 5'h15) begin
      fails++; $display("FAIL flags_load: Flags=%h want 15", Flags); end
    idle(); ALUFlags = 5'h0A;
    cyc();                                  // step 3 -> 4, no wFlags
    tests++; if (Flags !== 5'h15 || Counter !== 4'h4) begin
      fails++; $display("FAIL flags_hold: Flags=%h Counter=%h want 15/4", Flags, Counter); end
    CounterRST = 1;
    cyc();
    tests++; if (Counter !== 4'h0 || IrqAck !== 0 || PC !== 16'h0001) begin
      fails++; $display("FAIL fetch_rst: Counter=%h Ack=%b PC=%h want 0/0/0001", Counter, IrqAck, PC); end
  endtask

  task automatic test_branch_wrap();
    idle(); CounterRST = 1; PCWriteFromD = 1; DataIn = 16'hFFFF;
    cyc();
    tests++; if (PC !== 16'hFFFF) begin
      fails++; $display("FAIL branch_load: PC=%h want ffff", PC); end
    PCWriteFromD = 0; PCW = 1;
    cyc();
    tests++; if (PC !== 16'h0000) begin
      fails++; $display("FAIL pc_wrap: PC=%h want 0000", PC); end
    PCWriteFromD = 1; PCW = 1; DataIn = 16'h0040;
    cyc();
    tests++; if (PC !== 16'h0040 || Counter !== 4'h0) begin
      fails++; $display("FAIL branch_prio: PC=%h Counter=%h want 0040/0", PC, Counter); end
    idle();
  endtask

  task automatic test_stall();
    idle(); CounterRST = 1; enableInterrupts = 1;
    cyc();
    tests++; if (IntEnable !== 1) begin
      fails++; $display("FAIL int_enable: IE=%b want 1", IntEnable); end
    idle(); cyc();                          // Counter 1
    // stalled with strobes active and an Irq pulse
    Stall = 1; Irq = 1; PCW = 1; DToInstr = 1; DataIn = 16'h5555; CounterRST = 1;
    cyc();
    Irq = 0;
    cyc(); cyc();
    tests++; if (Counter !== 4'h1 || PC !== 16'h0040 || Instr !== 16'h1234 || IrqAck !== 0 || IntEnable !== 1) begin
      fails++; $display("FAIL stall_hold: Counter=%h PC=%h Instr=%h Ack=%b IE=%b want 1/0040/1234/0/1", Counter, PC, Instr, IrqAck, IntEnable); end
    idle(); cyc();                          // Counter 2, pending not consumed
    tests++; if (PC !== 16'h0040 || IrqAck !== 0 || Counter !== 4'h2) begin
      fails++; $display("FAIL stall_noentry: PC=%h Ack=%b Counter=%h want 0040/0/2", PC, IrqAck, Counter); end
    CounterRST = 1; PCW = 1;
    cyc();
    tests++; if (PC !== 16'h0004 || SavedPC !== 16'h0041 || IrqAck !== 1 || IntEnable !== 0 || Counter !== 4'h0) begin
      fails++; $display("FAIL stall_entry: PC=%h SavedPC=%h Ack=%b IE=%b Counter=%h want 0004/0041/1/0/0", PC, SavedPC, IrqAck, IntEnable, Counter); end
    idle(); cyc();
    tests++; if (IrqAck !== 0 || PC !== 16'h0004) begin
      fails++; $display("FAIL stall_ack_pulse: Ack=%b PC=%h want 0/0004", IrqAck, PC); end
  endtask

  task automatic test_interrupt();
    idle(); CounterRST = 1; PCWriteFromD = 1; DataIn = 16'h0010;
    cyc();
    idle(); CounterRST = 1; enableInterrupts = 1;
    cyc();
    idle(); Irq = 1;                        // mid-instruction: only sets pending
    cyc();
    tests++; if (PC !== 16'h0010 || IrqAck !== 0 || IntEnable !== 1 || Counter !== 4'h1) begin
      fails++; $display("FAIL irq_wait: PC=%h Ack=%b IE=%b Counter=%h want 0010/0/1/1", PC, IrqAck, IntEnable, Counter); end
    idle(); CounterRST = 1; PCW = 1; enableInterrupts = 1;
    cyc();
    tests++; if (PC !== 16'h0004 || SavedPC !== 16'h0011 || IrqAck !== 1 || IntEnable !== 0 || Counter !== 4'h0) begin
      fails++; $display("FAIL irq_entry: PC=%h SavedPC=%h Ack=%b IE=%b Counter=%h want 0004/0011/1/0/0", PC, SavedPC, IrqAck, IntEnable, Counter); end
    idle(); CounterRST = 1; PCW = 1;
    cyc();
    tests++; if (IrqAck !== 0 || PC !== 16'h0005 || SavedPC !== 16'h0011) begin
      fails++; $display("FAIL irq_after: Ack=%b PC=%h SavedPC=%h want 0/0005/0011", IrqAck, PC, SavedPC); end
    idle();
  endtask

  task automatic test_overflow();
    idle(); CounterRST = 1; cyc(); idle();
    for (int i = 0; i < 15; i++) cyc();
    tests++; if (Counter !== 4'hF || StepOverflow !== 0) begin
      fails++; $display("FAIL ovf_pre: Counter=%h Ovf=%b want f/0", Counter, StepOverflow); end
    cyc();
    tests++; if (Counter !== 4'h0 || StepOverflow !== 1) begin
      fails++; $display("FAIL ovf_wrap: Counter=%h Ovf=%b want 0/1", Counter, StepOverflow); end
    CounterRST = 1; cyc(); cyc();
    tests++; if (StepOverflow !== 1) begin
      fails++; $display("FAIL ovf_sticky: Ovf=%b want 1", StepOverflow); end
    idle(); rst_n = 0; #1;
    tests++; if (StepOverflow !== 0) begin
      fails++; $display("FAIL ovf_reset: Ovf=%b want 0", StepOverflow); end
    @(negedge clk); rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_branch_wrap();
    test_stall();
    test_interrupt();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
